// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and the
// ceil(log2) helper used to size pointers and the occupancy counter.
package fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   // Smallest r such that 2**r >= n (returns 0 for n <= 1).
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_if.sv
// Request/response and status bundle of sync_fifo. The master side issues
// write/read/flush requests; the slave side (the FIFO) returns data and flags.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);

   localparam int CW = clog2(DEPTH) + 1;

   logic              flush;
   logic              write;
   logic [DATA_W-1:0] data_in;
   logic              read;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, write, data_in, read,
      input  data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, write, data_in, read,
      output data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface : sync_fifo_if

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store the write word at the addressed entry.
   // NOTE: the array has no reset branch; stale contents are harmless because
   // the pointers and count decide what is readable, and a reset-free array
   // maps onto plain storage cells.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; by default
// reads are registered with one cycle of latency and a rd_valid pulse.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1
) (
   input  logic        clk,
   input  logic        rst,   // asynchronous, active low
   sync_fifo_if.slave  bus
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              full;
   logic              empty;
   logic              wr_accept;
   logic              rd_accept;
   logic              ram_we;
   logic [DATA_W-1:0] head;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Flush wins over both requests, so nothing is accepted in a flush cycle.
   assign wr_accept = bus.write & ~full  & ~bus.flush;
   assign rd_accept = bus.read  & ~empty & ~bus.flush;

   // Gating with rst discards a write presented while reset is held.
   assign ram_we = wr_accept & rst;

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.data_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

`ifndef SYNC_FIFO_FWFT_EN
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rd_valid_q, rd_valid_d;
`endif

   // Next-state logic for pointers, occupancy, sticky errors and read data.
   // NOTE: every variable gets its hold value first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
`ifndef SYNC_FIFO_FWFT_EN
      dout_d     = dout_q;
      rd_valid_d = rd_accept;
`endif
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (bus.write && full)  ovf_d = 1'b1;
         if (bus.read  && empty) udf_d = 1'b1;
`ifndef SYNC_FIFO_FWFT_EN
         if (rd_accept) dout_d = head;
`endif
      end
   end

   // State registers with asynchronous active-low clear.
   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
`ifndef SYNC_FIFO_FWFT_EN
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
`endif
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word falls through whenever something is stored; zero otherwise.
   assign bus.data_out = empty ? '0 : head;
   assign bus.rd_valid = ~empty;
`else
   assign bus.data_out = dout_q;
   assign bus.rd_valid = rd_valid_q;
`endif

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= CW'(AFULL_TH));
   assign bus.almost_empty = (count_q <= CW'(AEMPTY_TH));
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DATA_W=8, DEPTH=8 with default thresholds.
module tb_sync_fifo;
   import fifo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   sync_fifo_if #(.DATA_W(8), .DEPTH(8)) ff_if ();

   sync_fifo #(.DATA_W(8), .DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ff_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] d);
      ff_if.write   = 1'b1;
      ff_if.data_in = d;
      tick();
      ff_if.write   = 1'b0;
   endtask

   task automatic do_read();
      ff_if.read = 1'b1;
      tick();
      ff_if.read = 1'b0;
   endtask

   task automatic do_both(input logic [7:0] d);
      ff_if.write   = 1'b1;
      ff_if.read    = 1'b1;
      ff_if.data_in = d;
      tick();
      ff_if.write   = 1'b0;
      ff_if.read    = 1'b0;
   endtask

   task automatic do_flush();
      ff_if.flush = 1'b1;
      tick();
      ff_if.flush = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},  32'(ff_if.count), 32'd0);
      check({tag, "_empty"},  32'(ff_if.empty), 32'd1);
      check({tag, "_aempty"}, 32'(ff_if.almost_empty), 32'd1);
      check({tag, "_full"},   32'(ff_if.full), 32'd0);
      check({tag, "_afull"},  32'(ff_if.almost_full), 32'd0);
      check({tag, "_rdv"},    32'(ff_if.rd_valid), 32'd0);
      check({tag, "_ovf"},    32'(ff_if.overflow), 32'd0);
      check({tag, "_udf"},    32'(ff_if.underflow), 32'd0);
      check({tag, "_dout"},   32'(ff_if.data_out), 32'd0);
   endtask

   // Watchdog: the directed sequence is short; anything this long is a hang.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      ff_if.flush   = 1'b0;
      ff_if.write   = 1'b0;
      ff_if.read    = 1'b0;
      ff_if.data_in = '0;

      // Reset values while rst is held low
      tick();
      tick();
      check_reset_state("rst");
      rst = 1'b1;
      tick();

`ifdef SYNC_FIFO_FWFT_EN
      // Head word visible right after the write, no read needed
      do_write(8'hA5);
      check("fwft_dout", 32'(ff_if.data_out), 32'hA5);
      check("fwft_rdv",  32'(ff_if.rd_valid), 32'd1);
      check("fwft_cnt",  32'(ff_if.count), 32'd1);
      do_write(8'h5A);
      do_read();
      check("fwft_dout2", 32'(ff_if.data_out), 32'h5A);
      check("fwft_cnt2",  32'(ff_if.count), 32'd1);
      do_read();
      check("fwft_empty", 32'(ff_if.empty), 32'd1);
      check("fwft_rdv0",  32'(ff_if.rd_valid), 32'd0);
      do_read();
      check("fwft_udf",   32'(ff_if.underflow), 32'd1);
`else
      // Fill with 0x11..0x88
      for (int i = 1; i <= 8; i++) begin
         do_write(8'(i * 17));
         check($sformatf("fill_cnt%0d", i),   32'(ff_if.count), 32'(i));
         check($sformatf("fill_afull%0d", i), 32'(ff_if.almost_full), (i >= 7) ? 32'd1 : 32'd0);
         check($sformatf("fill_full%0d", i),  32'(ff_if.full), (i == 8) ? 32'd1 : 32'd0);
         check($sformatf("fill_aempty%0d", i), 32'(ff_if.almost_empty), (i <= 1) ? 32'd1 : 32'd0);
      end
      // Ninth write is rejected and sets overflow
      do_write(8'h99);
      check("ovf_flag", 32'(ff_if.overflow), 32'd1);
      check("ovf_cnt",  32'(ff_if.count), 32'd8);
      check("ovf_full", 32'(ff_if.full), 32'd1);

      // Drain: data one cycle after each read, rd_valid a one-cycle pulse
      for (int i = 1; i <= 8; i++) begin
         do_read();
         check($sformatf("drain_dout%0d", i), 32'(ff_if.data_out), 32'(i * 17));
         check($sformatf("drain_rdv%0d", i),  32'(ff_if.rd_valid), 32'd1);
         check($sformatf("drain_cnt%0d", i),  32'(ff_if.count), 32'(8 - i));
         tick();
         check($sformatf("drain_rdv_low%0d", i), 32'(ff_if.rd_valid), 32'd0);
         check($sformatf("drain_hold%0d", i),    32'(ff_if.data_out), 32'(i * 17));
      end
      check("drain_empty", 32'(ff_if.empty), 32'd1);
      do_read();
      check("udf_flag", 32'(ff_if.underflow), 32'd1);
      check("udf_dout", 32'(ff_if.data_out), 32'h88);
      check("udf_rdv",  32'(ff_if.rd_valid), 32'd0);
      check("udf_ovf_sticky", 32'(ff_if.overflow), 32'd1);

      // Flush at count 5 with overflow still set
      for (int i = 1; i <= 5; i++) do_write(8'(i));
      check("pre_flush_cnt", 32'(ff_if.count), 32'd5);
      do_flush();
      check("flush_cnt",   32'(ff_if.count), 32'd0);
      check("flush_empty", 32'(ff_if.empty), 32'd1);
      check("flush_ovf",   32'(ff_if.overflow), 32'd0);
      check("flush_udf",   32'(ff_if.underflow), 32'd0);
      check("flush_dout",  32'(ff_if.data_out), 32'h88);

      // Wrap-around: 4 writes, 8 write+read pairs, 4 reads
      for (int k = 0; k < 4; k++) do_write(8'(8'h20 + k));
      for (int k = 0; k < 8; k++) begin
         do_both(8'(8'h24 + k));
         check($sformatf("wrap_dout%0d", k), 32'(ff_if.data_out), 32'(8'h20 + k));
         check($sformatf("wrap_cnt%0d", k),  32'(ff_if.count), 32'd4);
      end
      for (int k = 0; k < 4; k++) begin
         do_read();
         check($sformatf("wrap_tail%0d", k), 32'(ff_if.data_out), 32'(8'h28 + k));
         check($sformatf("wrap_tcnt%0d", k), 32'(ff_if.count), 32'(3 - k));
      end
      check("wrap_empty", 32'(ff_if.empty), 32'd1);

      // Simultaneous read and write at count 3
      do_write(8'h31);
      do_write(8'h32);
      do_write(8'h33);
      do_both(8'h34);
      check("both3_cnt",  32'(ff_if.count), 32'd3);
      check("both3_dout", 32'(ff_if.data_out), 32'h31);

      // Simultaneous read and write when full: only the read goes through
      do_flush();
      check("flush2_cnt", 32'(ff_if.count), 32'd0);
      for (int k = 0; k < 8; k++) do_write(8'(8'h40 + k));
      do_both(8'h48);
      check("bothf_cnt",  32'(ff_if.count), 32'd7);
      check("bothf_dout", 32'(ff_if.data_out), 32'h40);
      check("bothf_ovf",  32'(ff_if.overflow), 32'd1);
      do_read();
      check("bothf_next", 32'(ff_if.data_out), 32'h41);
      check("bothf_cnt2", 32'(ff_if.count), 32'd6);

      // Simultaneous read and write when empty: only the write goes through
      do_flush();
      do_both(8'h50);
      check("bothe_cnt",  32'(ff_if.count), 32'd1);
      check("bothe_udf",  32'(ff_if.underflow), 32'd1);
      check("bothe_rdv",  32'(ff_if.rd_valid), 32'd0);
      do_read();
      check("bothe_dout", 32'(ff_if.data_out), 32'h50);
      check("bothe_empty", 32'(ff_if.empty), 32'd1);

      // Reset mid-burst with a write in flight
      do_write(8'hD1);
      do_write(8'hD2);
      ff_if.write   = 1'b1;
      ff_if.data_in = 8'hD3;
      #2;
      rst = 1'b0;
      #1;
      check_reset_state("midrst");
      tick();
      check("midrst_cnt_held", 32'(ff_if.count), 32'd0);
      ff_if.write = 1'b0;
      rst = 1'b1;
      tick();
      do_write(8'hE7);
      do_write(8'hE8);
      do_read();
      check("postrst_dout", 32'(ff_if.data_out), 32'hE7);
      check("postrst_cnt",  32'(ff_if.count), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 8, meaning number of entries; legal values are powers of two, 2 or more.
REQ-003 The block SHALL provide parameter AFULL_TH, default DEPTH-1, meaning the almost_full threshold in entries.
REQ-004 The block SHALL provide parameter AEMPTY_TH, default 1, meaning the almost_empty threshold in entries.
REQ-005 The block SHALL have port clk  input  1  single clock, all state updated on the rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port flush  input  1  synchronous clear of FIFO state.
REQ-008 The block SHALL have port write  input  1  write request.
REQ-009 The block SHALL have port data_in  input  DATA_W  write data.
REQ-010 The block SHALL have port read  input  1  read request.
REQ-011 The block SHALL have port data_out  output  DATA_W  read data.
REQ-012 The block SHALL have port rd_valid  output  1  data_out holds a valid popped or head word.
REQ-013 The block SHALL have the status ports full, empty, almost_full, almost_empty  output  1 each.
REQ-014 The block SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-015 The block SHALL have the sticky error ports overflow, underflow  output  1 each.

Function
REQ-016 Write acceptance and read acceptance SHALL be decided independently.
- A write SHALL be accepted iff write=1 and full=0; data_in is stored at the write pointer and the pointer advances, wrapping at DEPTH.
- A read SHALL be accepted iff read=1 and empty=0; the read pointer advances, wrapping at DEPTH.
REQ-017 Simultaneous accepted read and write SHALL leave count unchanged.
- When full with both requested, only the read is accepted and count decrements.
- When empty with both requested, only the write is accepted and count increments.
REQ-018 Status flags SHALL be derived from the registered count and change in the same cycle as count.
- full = (count==DEPTH); empty = (count==0).
- almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH).
REQ-019 The overflow flag SHALL set on write=1 while full=1 and hold until flush or reset.
REQ-020 The underflow flag SHALL set on read=1 while empty=1 and hold until flush or reset.
REQ-021 In registered-read mode:
- An accepted read SHALL load data_out with the head word at the clock edge, giving 1-cycle latency, and pulse rd_valid high for that one cycle.
- data_out SHALL hold its value otherwise.
REQ-022 flush=1 SHALL take priority over read and write.
- Next cycle: pointers 0, count 0, rd_valid 0, overflow 0, underflow 0.
- Memory contents and data_out are unchanged.
REQ-023 Memory SHALL be sized exactly DEPTH entries and SHALL never be written when the write is rejected.

Reset
REQ-024 While rst=0, the block SHALL drive:
- pointers, count and data_out to 0;
- empty=1, almost_empty=1;
- full, almost_full, rd_valid, overflow and underflow to 0.
Memory array contents are not reset.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight reads and writes; the first accepted write after release SHALL land in entry 0.

Configuration
REQ-026 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
- With the macro defined: data_out shows the head entry combinationally whenever empty=0, rd_valid=~empty, and read pops the head with zero latency.
- Without the macro: the registered-read behaviour of REQ-021 applies.

Structure
REQ-027 The shared package fifo_pkg SHALL hold:
- the pointer/count width function (ceil log2);
- the default DATA_W and DEPTH constants.
REQ-028 Storage SHALL be a sub-module fifo_ram, a DEPTH x DATA_W register array with synchronous write port and asynchronous read port. Pointer, count, flag and output logic stay in sync_fifo.

Verification (DATA_W=8, DEPTH=8, defaults)
REQ-029 The bench SHALL cover the following scenarios:
- Reset, then write 0x11..0x88 (8 writes) -> count 8, full=1, almost_full asserted at count 7; 9th write 0x99 -> rejected, overflow=1, contents unchanged.
- Read 8 times (registered mode) -> data_out 0x11..0x88, each one cycle after its read, with rd_valid pulsing; then empty=1; 9th read -> underflow=1, data_out holds 0x88.
- Wrap-around: write 12, read 12, interleaved -> order preserved across pointer wrap, count never exceeds 8.
- Simultaneous read and write at count 3 -> count stays 3.
- Simultaneous read and write when full -> count 7.
- Simultaneous read and write when empty -> count 1.
- Assert flush at count 5 with overflow set -> next cycle count 0, empty=1, overflow 0.
- Assert rst mid-burst -> all outputs at reset values.
- SYNC_FIFO_FWFT_EN defined, write 0xA5 -> data_out=0xA5 and rd_valid=1 the cycle after the write with no read; read -> empty=1 next cycle.
